// File: rtl/simple_fifo_reader_256.sv
// Drains a counted burst of words from an upstream simple_fifo into a valid/ready stream,
// using a 2-entry skid buffer so one-cycle FIFO read latency never throttles throughput.
module simple_fifo_reader_256 #(
  parameter int WIDTH = 256,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LEN_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] issue_cnt, deliv_cnt, issue_nxt, deliv_nxt;
  logic [WIDTH-1:0] ent0, ent1;
  logic [1:0]       occ, pend;
  logic             inflight, pop, cap;

  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? ent0 : '0;
  assign pop       = out_valid & out_ready;
  assign cap       = inflight;
  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);

  // Slot accounting credits an entry popped this cycle so a continuously
  // drained stream can issue a read every cycle without overflowing.
  assign pend    = occ + {1'b0, inflight} - {1'b0, pop};
  assign fifo_re = (state == RUN) && !fifo_empty && (issue_cnt != '0) && (pend < 2'd2);

  assign issue_nxt = issue_cnt - {{(LEN_W-1){1'b0}}, fifo_re};
  assign deliv_nxt = deliv_cnt - {{(LEN_W-1){1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? RUN : DONE;
      RUN:     if (issue_nxt == '0) state_nxt = FLUSH;
      FLUSH:   if (deliv_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      issue_cnt <= '0;
      deliv_cnt <= '0;
      out_count <= '0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      ent0      <= '0;
      ent1      <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_re;
      if (state == IDLE && start) begin
        issue_cnt <= len;
        deliv_cnt <= len;
        out_count <= '0;
      end else begin
        issue_cnt <= issue_nxt;
        deliv_cnt <= deliv_nxt;
        if (pop) out_count <= out_count + 1'b1;
      end
      occ <= occ + {1'b0, cap} - {1'b0, pop};
      // ent0 is always the oldest word; ent1 only holds data when occ==2.
      case ({cap, pop})
        2'b01: ent0 <= ent1;
        2'b10: begin
          if (occ == 2'd0) ent0 <= fifo_dout;
          else             ent1 <= fifo_dout;
        end
        2'b11: begin
          if (occ == 2'd1) ent0 <= fifo_dout;
          else begin
            ent0 <= ent1;
            ent1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
